// File: rtl/sd_cmd_engine_if.sv
// Command/response and byte-shifter signals of the SD command engine, bundled as one interface.
// The engine is the slave; the upstream controller plus SPI shifter form the master side.
interface sd_cmd_engine_if #(
    parameter int MAX_EXTRA = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [5:0]               cmd_index;
    logic [31:0]              cmd_arg;
    logic [2:0]               resp_extra;
    logic                     resp_valid;
    logic [7:0]               resp_r1;
    logic [8*MAX_EXTRA-1:0]   resp_data;
    logic                     resp_timeout;
    logic                     cs_assert;
    logic                     xfer_start;
    logic [7:0]               xfer_tx;
    logic                     xfer_done;
    logic [7:0]               xfer_rx;

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, resp_extra, xfer_done, xfer_rx,
        output cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout,
               cs_assert, xfer_start, xfer_tx
    );

    modport master (
        output cmd_valid, cmd_index, cmd_arg, resp_extra, xfer_done, xfer_rx,
        input  cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout,
               cs_assert, xfer_start, xfer_tx
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD SPI command engine: frames index+argument+CRC7 into a 6-byte token, drives it byte by byte
// through the SPI shifter, polls for R1, captures trailing response bytes and reports the result.
module sd_cmd_engine #(
    parameter int RESP_TIMEOUT = 8,
    parameter int MAX_EXTRA    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_cmd_engine_if.slave    bus
);
    localparam int DW = 8 * MAX_EXTRA;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SEND, S_POLL, S_DATA, S_TRAIL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     arg_q, arg_d;
    logic [2:0]      extra_q, extra_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      poll_q, poll_d;
    logic [6:0]      crc_q, crc_d;
    logic            pend_q, pend_d;
    logic            start_q, start_d;
    logic [7:0]      tx_q, tx_d;
    logic            cs_q, cs_d;
    logic [7:0]      r1_q, r1_d;
    logic [DW-1:0]   data_q, data_d;
    logic            tmo_q, tmo_d;

    logic [7:0]      frame_byte;
    logic [2:0]      extra_clamped;

    // CRC7 (x^7 + x^3 + 1), MSB first, one byte at a time
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign extra_clamped = (bus.resp_extra > 3'(MAX_EXTRA)) ? 3'(MAX_EXTRA) : bus.resp_extra;

    always_comb begin
        frame_byte = {crc_q, 1'b1};
        case (cnt_q)
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = {crc_q, 1'b1};
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        extra_d = extra_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        crc_d   = crc_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        tx_d    = tx_q;
        cs_d    = cs_q;
        r1_d    = r1_q;
        data_d  = data_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    idx_d   = bus.cmd_index;
                    arg_d   = bus.cmd_arg;
                    extra_d = extra_clamped;
                    data_d  = '0;
                    tmo_d   = 1'b0;
                    r1_d    = 8'hFF;
                    crc_d   = 7'd0;
                    cnt_d   = 3'd0;
                    cs_d    = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                // One byte in flight at a time: issue when nothing is pending, advance on its done.
                if (!pend_q) begin
                    start_d = 1'b1;
                    pend_d  = 1'b1;
                    tx_d    = (state_q == S_SEND) ? frame_byte : 8'hFF;
                    if (state_q == S_SEND && cnt_q < 3'd5)
                        crc_d = crc7_byte(crc_q, frame_byte);
                end else if (bus.xfer_done) begin
                    pend_d = 1'b0;
                    case (state_q)
                        S_PRE: begin
                            cnt_d   = 3'd0;
                            crc_d   = 7'd0;
                            state_d = S_SEND;
                        end
                        S_SEND: begin
                            if (cnt_q == 3'd5) begin
                                poll_d  = 8'd0;
                                state_d = S_POLL;
                            end else begin
                                cnt_d = cnt_q + 3'd1;
                            end
                        end
                        S_POLL: begin
                            poll_d = poll_q + 8'd1;
                            if (!bus.xfer_rx[7]) begin
                                r1_d = bus.xfer_rx;
                                if (extra_q == 3'd0) begin
                                    cs_d    = 1'b0;
                                    state_d = S_TRAIL;
                                end else begin
                                    cnt_d   = 3'd0;
                                    state_d = S_DATA;
                                end
                            end else if (poll_q + 8'd1 == 8'(RESP_TIMEOUT)) begin
                                tmo_d   = 1'b1;
                                cs_d    = 1'b0;
                                state_d = S_TRAIL;
                            end
                        end
                        S_DATA: begin
                            data_d = DW'({data_q, bus.xfer_rx});
                            cnt_d  = cnt_q + 3'd1;
                            if (cnt_q + 3'd1 == extra_q) begin
                                cs_d    = 1'b0;
                                state_d = S_TRAIL;
                            end
                        end
                        S_TRAIL: begin
                            state_d = S_DONE;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            arg_q   <= '0;
            extra_q <= '0;
            cnt_q   <= '0;
            poll_q  <= '0;
            crc_q   <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= 8'hFF;
            cs_q    <= 1'b0;
            r1_q    <= 8'hFF;
            data_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            extra_q <= extra_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            crc_q   <= crc_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            cs_q    <= cs_d;
            r1_q    <= r1_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.resp_valid   = (state_q == S_DONE);
    assign bus.resp_r1      = r1_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_timeout = tmo_q;
    assign bus.cs_assert    = cs_q;
    assign bus.xfer_start   = start_q;
    assign bus.xfer_tx      = tx_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: a behavioural SPI byte shifter answers each exchange from a
// queue of receive bytes and logs every transmitted byte with the chip-select level at its start.
module tb_sd_cmd_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_engine_if #(.MAX_EXTRA(4)) bus ();

    sd_cmd_engine #(.RESP_TIMEOUT(8), .MAX_EXTRA(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic       cs_log[$];
    logic [7:0] exp_tx[$];

    int busy = 0;
    int lat = 0;
    int overlap_viol = 0;
    int start_cnt = 0;
    int rv_cnt = 0;
    int rv_base = 0;
    int acc_cnt = 0;
    bit spur_req = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Byte shifter model: 3-cycle exchange latency, done/rx driven on the falling edge
    initial begin : shifter
        bus.xfer_done = 1'b0;
        bus.xfer_rx   = 8'h00;
        forever begin
            @(negedge clk);
            bus.xfer_done = 1'b0;
            if (spur_req) begin
                bus.xfer_done = 1'b1;
                bus.xfer_rx   = 8'h00;
                spur_req      = 1'b0;
            end else if (bus.xfer_start === 1'b1) begin
                start_cnt++;
                if (busy != 0) overlap_viol++;
                else begin
                    tx_log.push_back(bus.xfer_tx);
                    cs_log.push_back(bus.cs_assert);
                    busy = 1;
                    lat  = 3;
                end
            end else if (busy != 0) begin
                lat--;
                if (lat == 0) begin
                    busy = 0;
                    bus.xfer_done = 1'b1;
                    bus.xfer_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) rv_cnt++;
            if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) acc_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] extra);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_index  = idx;
        bus.cmd_arg    = arg;
        bus.resp_extra = extra;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_index  = 6'h3F;
        bus.cmd_arg    = 32'hDEADBEEF;
        bus.resp_extra = 3'd5;
        if (!got) check_eq("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        bit got = 1'b0;
        rv_base = rv_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (rv_cnt > rv_base) begin got = 1'b1; break; end
        end
        if (!got) check_eq({tag, "_resp_timeout"}, 32'(got), 32'd1);
        else $display("resp %s: r1=%02h data=%08h timeout=%0d bytes=%0d",
                      tag, bus.resp_r1, bus.resp_data, bus.resp_timeout, tx_log.size());
    endtask

    task automatic check_frame(input string tag);
        int n;
        check_eq({tag, "_len"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
    endtask

    task automatic clear_logs();
        tx_log.delete();
        cs_log.delete();
        rx_q.delete();
    endtask

    task automatic load_cmd0_rx();
        repeat (8) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h01);
    endtask

    initial begin : stim
        int sc;
        int ab;
        bit got;
        bus.cmd_valid  = 1'b0;
        bus.cmd_index  = 6'd0;
        bus.cmd_arg    = 32'd0;
        bus.resp_extra = 3'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cs_during", 32'(bus.cs_assert), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_cs", 32'(bus.cs_assert), 32'd0);
        check_eq("rst_start", 32'(bus.xfer_start), 32'd0);
        check_eq("rst_tx", 32'(bus.xfer_tx), 32'hFF);
        check_eq("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_r1", 32'(bus.resp_r1), 32'hFF);
        check_eq("rst_data", bus.resp_data, 32'd0);
        check_eq("rst_tmo", 32'(bus.resp_timeout), 32'd0);

        // CMD0, R1 on second poll
        clear_logs();
        load_cmd0_rx();
        exp_tx = {8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(6'd0, 32'h0, 3'd0);
        wait_resp("cmd0");
        check_eq("cmd0_r1", 32'(bus.resp_r1), 32'h01);
        check_eq("cmd0_tmo", 32'(bus.resp_timeout), 32'd0);
        check_frame("cmd0");
        for (int i = 0; i < cs_log.size(); i++)
            check_eq($sformatf("cmd0_cs%0d", i), 32'(cs_log[i]),
                     (i == cs_log.size() - 1) ? 32'd0 : 32'd1);
        repeat (20) @(negedge clk);
        check_eq("cmd0_one_pulse", 32'(rv_cnt - rv_base), 32'd1);
        check_eq("cmd0_cs_idle", 32'(bus.cs_assert), 32'd0);

        // CMD8 with R7 trailing bytes
        clear_logs();
        repeat (7) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h01); rx_q.push_back(8'hAA);
        exp_tx = {8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(6'd8, 32'h0000_01AA, 3'd4);
        wait_resp("cmd8");
        check_eq("cmd8_r1", 32'(bus.resp_r1), 32'h01);
        check_eq("cmd8_data", bus.resp_data, 32'h0000_01AA);
        check_eq("cmd8_tmo", 32'(bus.resp_timeout), 32'd0);
        check_frame("cmd8");

        // CMD58 that never answers: 8 polls, no DATA bytes
        clear_logs();
        exp_tx = {8'hFF, 8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD};
        repeat (9) exp_tx.push_back(8'hFF);
        send_cmd(6'd58, 32'h0, 3'd4);
        wait_resp("cmd58");
        check_eq("cmd58_tmo", 32'(bus.resp_timeout), 32'd1);
        check_eq("cmd58_r1", 32'(bus.resp_r1), 32'hFF);
        check_eq("cmd58_data", bus.resp_data, 32'd0);
        check_frame("cmd58");

        // resp_extra=7 clamps to 4 data bytes
        clear_logs();
        repeat (7) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        rx_q.push_back(8'h55); rx_q.push_back(8'h66);
        exp_tx = {8'hFF, 8'h69, 8'h40, 8'h00, 8'h00, 8'h00, 8'h77, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(6'd41, 32'h4000_0000, 3'd7);
        wait_resp("cmd41");
        check_eq("cmd41_r1", 32'(bus.resp_r1), 32'h00);
        check_eq("cmd41_data", bus.resp_data, 32'h1122_3344);
        check_frame("cmd41");

        // cmd_valid held while busy: second command waits for resp_valid
        clear_logs();
        repeat (7) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'hFF);
        load_cmd0_rx();
        exp_tx = {8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65, 8'hFF, 8'hFF,
                  8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        ab = acc_cnt;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_index  = 6'd55;
        bus.cmd_arg    = 32'h0;
        bus.resp_extra = 3'd0;
        @(posedge clk); #1;
        bus.cmd_index  = 6'd0;
        wait_resp("hold1");
        check_eq("hold_acc_first", 32'(acc_cnt - ab), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin got = 1'b1; break; end
        end
        check_eq("hold_ready_again", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_resp("hold2");
        check_eq("hold_acc_total", 32'(acc_cnt - ab), 32'd2);
        check_eq("hold_r1", 32'(bus.resp_r1), 32'h01);
        check_frame("hold");

        // Spurious xfer_done while idle
        sc = start_cnt;
        @(posedge clk); #1;
        spur_req = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("spur_no_start", 32'(start_cnt - sc), 32'd0);
        check_eq("spur_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("spur_cs", 32'(bus.cs_assert), 32'd0);

        // Reset in the middle of SEND, then a clean CMD0
        clear_logs();
        send_cmd(6'd8, 32'h0000_01AA, 3'd4);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_log.size() >= 4) begin got = 1'b1; break; end
        end
        check_eq("rst_mid_reached_b2", 32'(got), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cs", 32'(bus.cs_assert), 32'd0);
        check_eq("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        check_eq("rst_mid_cs_hold", 32'(bus.cs_assert), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_mid_idle_start", 32'(bus.xfer_start), 32'd0);
        clear_logs();
        load_cmd0_rx();
        exp_tx = {8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(6'd0, 32'h0, 3'd0);
        wait_resp("rst_cmd0");
        check_eq("rst_cmd0_r1", 32'(bus.resp_r1), 32'h01);
        check_eq("rst_cmd0_data", bus.resp_data, 32'd0);
        check_frame("rst_cmd0");

        check_eq("no_overlap", 32'(overlap_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
